// File: rtl/nec_tick_ctrl.sv
// Programmable tick scheduler for the NEC IR receive path: base tick prescaler,
// divide-by-8 strobe and a frame-gap timeout counted in tick_div8 units.
module nec_tick_ctrl #(
  parameter int PRESCALE_W = 16,
  parameter int TMO_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_en,
  input  logic [PRESCALE_W-1:0] cfg_prescale,
  input  logic                  cfg_load,
  output logic                  cfg_busy,
  output logic                  tick,
  output logic                  tick_div8,
  input  logic                  tmo_start,
  input  logic [TMO_W-1:0]      tmo_limit,
  output logic                  tmo_active,
  output logic                  tmo_expired
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_RELOAD
  } state_t;

  state_t                r_state;
  logic [PRESCALE_W-1:0] r_pcnt;
  logic [PRESCALE_W-1:0] r_active;
  logic [PRESCALE_W-1:0] r_shadow;
  logic                  r_busy;
  logic                  r_tick;
  logic [2:0]            r_div;
  logic                  r_tick_div8;
  logic [TMO_W-1:0]      r_tcnt;
  logic                  r_tmo_active;
  logic                  r_tmo_expired;

  state_t                w_state_nxt;
  logic [PRESCALE_W-1:0] w_pcnt_nxt;
  logic [PRESCALE_W-1:0] w_active_nxt;
  logic [PRESCALE_W-1:0] w_shadow_nxt;
  logic                  w_busy_nxt;
  logic                  w_tick_nxt;
  logic [2:0]            w_div_nxt;
  logic                  w_tick_div8_nxt;
  logic [TMO_W-1:0]      w_tcnt_nxt;
  logic                  w_tmo_active_nxt;
  logic                  w_tmo_expired_nxt;
  logic                  w_wrap;

  assign w_wrap = (r_pcnt == r_active);

  always_comb begin
    w_state_nxt       = r_state;
    w_pcnt_nxt        = r_pcnt;
    w_active_nxt      = r_active;
    w_shadow_nxt      = r_shadow;
    w_busy_nxt        = r_busy;
    w_tick_nxt        = 1'b0;
    w_div_nxt         = r_div;
    w_tick_div8_nxt   = 1'b0;
    w_tcnt_nxt        = r_tcnt;
    w_tmo_active_nxt  = r_tmo_active;
    w_tmo_expired_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_pcnt_nxt       = '0;
        w_shadow_nxt     = '0;
        w_busy_nxt       = 1'b0;
        w_div_nxt        = '0;
        w_tcnt_nxt       = '0;
        w_tmo_active_nxt = 1'b0;
        if (cfg_load) w_active_nxt = cfg_prescale;
        if (cfg_en)   w_state_nxt  = S_RUN;
      end
      default: begin
        if (!cfg_en) begin
          w_state_nxt      = S_IDLE;
          w_pcnt_nxt       = '0;
          w_shadow_nxt     = '0;
          w_busy_nxt       = 1'b0;
          w_div_nxt        = '0;
          w_tcnt_nxt       = '0;
          w_tmo_active_nxt = 1'b0;
        end else begin
          if (w_wrap) begin
            w_pcnt_nxt = '0;
            w_tick_nxt = 1'b1;
          end else begin
            w_pcnt_nxt = r_pcnt + 1'b1;
          end

          // A load landing on the RUN wrap cycle is deferred to the following wrap.
          if (r_state == S_RUN && cfg_load) begin
            w_shadow_nxt = cfg_prescale;
            w_busy_nxt   = 1'b1;
            w_state_nxt  = S_RELOAD;
          end else if (r_state == S_RELOAD && w_wrap) begin
            w_active_nxt = r_shadow;
            w_busy_nxt   = 1'b0;
            w_state_nxt  = S_RUN;
          end

          if (r_tick) begin
            w_div_nxt = r_div + 3'd1;
            if (r_div == 3'd7) w_tick_div8_nxt = 1'b1;
          end

          // Restart takes priority over a coincident expiry.
          if (tmo_start) begin
            w_tcnt_nxt       = tmo_limit;
            w_tmo_active_nxt = 1'b1;
          end else if (r_tmo_active && r_tick_div8) begin
            if (r_tcnt == '0) begin
              w_tmo_expired_nxt = 1'b1;
              w_tmo_active_nxt  = 1'b0;
            end else begin
              w_tcnt_nxt = r_tcnt - 1'b1;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_pcnt        <= '0;
      r_active      <= '0;
      r_shadow      <= '0;
      r_busy        <= 1'b0;
      r_tick        <= 1'b0;
      r_div         <= '0;
      r_tick_div8   <= 1'b0;
      r_tcnt        <= '0;
      r_tmo_active  <= 1'b0;
      r_tmo_expired <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pcnt        <= w_pcnt_nxt;
      r_active      <= w_active_nxt;
      r_shadow      <= w_shadow_nxt;
      r_busy        <= w_busy_nxt;
      r_tick        <= w_tick_nxt;
      r_div         <= w_div_nxt;
      r_tick_div8   <= w_tick_div8_nxt;
      r_tcnt        <= w_tcnt_nxt;
      r_tmo_active  <= w_tmo_active_nxt;
      r_tmo_expired <= w_tmo_expired_nxt;
    end
  end

  assign cfg_busy    = r_busy;
  assign tick        = r_tick;
  assign tick_div8   = r_tick_div8;
  assign tmo_active  = r_tmo_active;
  assign tmo_expired = r_tmo_expired;

endmodule

// File: tb/tb_nec_tick_ctrl.sv
// Directed bench for nec_tick_ctrl: a tick-schedule model pushes expected strobe
// times into queues; a negedge monitor pops and compares them as strobes appear.
module tb_nec_tick_ctrl;
  localparam int PW = 16;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_en = 1'b0;
  logic [PW-1:0] cfg_prescale = '0;
  logic          cfg_load = 1'b0;
  logic          tmo_start = 1'b0;
  logic [TW-1:0] tmo_limit = '0;
  logic          cfg_busy, tick, tick_div8, tmo_active, tmo_expired;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int q_tick[$];
  int q_div8[$];
  int q_exp[$];
  int all_d8[$];
  int nt = 0, per = 1, ntick = 0, sw_at = -1, pend = 1;
  bit model_on = 1'b0;
  int e_t, e_d, e_x;
  int s, d, e, t;

  nec_tick_ctrl #(.PRESCALE_W(PW), .TMO_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_prescale(cfg_prescale),
    .cfg_load(cfg_load), .cfg_busy(cfg_busy), .tick(tick), .tick_div8(tick_div8),
    .tmo_start(tmo_start), .tmo_limit(tmo_limit), .tmo_active(tmo_active),
    .tmo_expired(tmo_expired)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Strobe monitor: every observed strobe must match the oldest expected time.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tick) begin
        e_t = (q_tick.size() > 0) ? q_tick.pop_front() : -1;
        chk("tick_time", cyc, e_t);
      end
      if (tick_div8) begin
        e_d = (q_div8.size() > 0) ? q_div8.pop_front() : -1;
        chk("div8_time", cyc, e_d);
      end
      if (tmo_expired) begin
        e_x = (q_exp.size() > 0) ? q_exp.pop_front() : -1;
        chk("expired_time", cyc, e_x);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic gen_ticks(int upto);
    if (!model_on) return;
    while (nt <= upto) begin
      q_tick.push_back(nt);
      ntick++;
      if (ntick % 8 == 0) begin
        q_div8.push_back(nt + 1);
        all_d8.push_back(nt + 1);
      end
      if (nt == sw_at) begin
        per   = pend;
        sw_at = -1;
      end
      nt += per;
    end
  endtask

  task automatic run(int n);
    repeat (n) begin
      gen_ticks(cyc + 1);
      step();
    end
  endtask

  task automatic run_to(int tt);
    for (int i = 0; i < 5000 && cyc < tt; i++) run(1);
  endtask

  task automatic start_model();
    model_on = 1'b1;
    ntick    = 0;
    nt       = cyc + per;
    sw_at    = -1;
  endtask

  // In RUN the new period starts after the first wrap strictly after the load edge.
  task automatic do_load(int v);
    cfg_prescale = PW'(v);
    cfg_load     = 1'b1;
    run(1);
    cfg_load = 1'b0;
    if (model_on) begin
      sw_at = nt;
      pend  = v + 1;
    end else begin
      per = v + 1;
    end
  endtask

  // k-th tick_div8 cycle D with D >= s (counted by the timeout started at edge s).
  function automatic int find_d8(int st, int k);
    int cnt = 0;
    int tt  = nt;
    int n   = ntick;
    foreach (all_d8[i]) begin
      if (all_d8[i] >= st) begin
        cnt++;
        if (cnt == k) return all_d8[i];
      end
    end
    for (int it = 0; it < 100000; it++) begin
      n++;
      if (n % 8 == 0 && tt + 1 >= st) begin
        cnt++;
        if (cnt == k) return tt + 1;
      end
      tt += per;
    end
    return -1;
  endfunction

  task automatic chk_all_low(string tag);
    chk({tag, "_tick"}, tick, 0);
    chk({tag, "_div8"}, tick_div8, 0);
    chk({tag, "_busy"}, cfg_busy, 0);
    chk({tag, "_active"}, tmo_active, 0);
    chk({tag, "_expired"}, tmo_expired, 0);
  endtask

  task automatic chk_drained(string tag);
    chk({tag, "_tick_q"}, q_tick.size(), 0);
    chk({tag, "_div8_q"}, q_div8.size(), 0);
    chk({tag, "_exp_q"}, q_exp.size(), 0);
  endtask

  initial begin
    // Reset state
    repeat (3) step();
    chk_all_low("reset");
    rst_n = 1'b1;
    run(2);
    chk_all_low("idle");

    // 1: P=3 loaded in IDLE, period 4, div8 period 32
    do_load(3);
    chk("idle_load_busy", cfg_busy, 0);
    cfg_en = 1'b1;
    run(1);
    start_model();
    run(80);

    // 2: mid-period load of 9, second load while busy ignored
    run(1);
    do_load(9);
    chk("reload_busy", cfg_busy, 1);
    t = sw_at;
    cfg_prescale = PW'(2);
    cfg_load = 1'b1;
    run(1);
    cfg_load = 1'b0;
    run_to(t - 1);
    chk("busy_before_wrap", cfg_busy, 1);
    run(1);
    chk("busy_after_wrap", cfg_busy, 0);
    run(100);

    // 3: P=0 then load of 5 applied on the next cycle
    do_load(0);
    run(80);
    do_load(5);
    chk("p0_load_busy", cfg_busy, 1);
    run(1);
    chk("p0_load_applied", cfg_busy, 0);
    run(80);

    // 4: timeout limit 2, then limit 0
    tmo_limit = TW'(2);
    tmo_start = 1'b1;
    run(1);
    s = cyc;
    tmo_start = 1'b0;
    chk("tmo2_active", tmo_active, 1);
    e = find_d8(s, 3) + 1;
    q_exp.push_back(e);
    run_to(e - 1);
    chk("tmo2_active_pre", tmo_active, 1);
    run(1);
    chk("tmo2_active_post", tmo_active, 0);
    run(5);

    tmo_limit = TW'(0);
    tmo_start = 1'b1;
    run(1);
    s = cyc;
    tmo_start = 1'b0;
    e = find_d8(s, 1) + 1;
    q_exp.push_back(e);
    run_to(e - 1);
    chk("tmo0_active_pre", tmo_active, 1);
    run(1);
    chk("tmo0_active_post", tmo_active, 0);
    run(5);

    // 5: restart in the expiry cycle suppresses the pulse
    tmo_limit = TW'(1);
    tmo_start = 1'b1;
    run(1);
    s = cyc;
    tmo_start = 1'b0;
    d = find_d8(s, 2);
    run_to(d);
    tmo_limit = TW'(0);
    tmo_start = 1'b1;
    run(1);
    tmo_start = 1'b0;
    s = cyc;
    chk("restart_no_pulse", tmo_expired, 0);
    chk("restart_active", tmo_active, 1);
    e = find_d8(s, 1) + 1;
    q_exp.push_back(e);
    run_to(e - 1);
    chk("restart_active_pre", tmo_active, 1);
    run(1);
    chk("restart_active_post", tmo_active, 0);
    run(5);

    // 6: cfg_en dropped in RELOAD with timeout active
    tmo_limit = TW'(5);
    tmo_start = 1'b1;
    run(1);
    tmo_start = 1'b0;
    t = nt;
    run_to(t);
    do_load(20);
    chk("drop_busy_pre", cfg_busy, 1);
    chk("drop_active_pre", tmo_active, 1);
    cfg_en   = 1'b0;
    model_on = 1'b0;
    run(1);
    chk_all_low("drop");
    run(20);
    chk_drained("drop");
    cfg_en = 1'b1;
    run(1);
    start_model();
    run(60);
    chk("reenable_busy", cfg_busy, 0);

    // Async reset mid-period
    tmo_limit = TW'(5);
    tmo_start = 1'b1;
    run(1);
    tmo_start = 1'b0;
    t = nt;
    run_to(t);
    do_load(7);
    chk("arst_busy_pre", cfg_busy, 1);
    chk("arst_active_pre", tmo_active, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_low("arst");
    model_on = 1'b0;
    q_tick.delete();
    q_div8.delete();
    q_exp.delete();
    cfg_en = 1'b0;
    run(3);
    rst_n = 1'b1;
    run(3);
    chk_all_low("post_arst");
    // Active prescale was cleared by reset: expect a tick every cycle
    cfg_en = 1'b1;
    run(1);
    per = 1;
    start_model();
    run(20);
    model_on = 1'b0;
    cfg_en   = 1'b0;
    run(1);
    chk_all_low("final_idle");
    run(3);
    chk_drained("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
